// File: rtl/seq_s_feeder.sv
// seq_s_feeder: packs the host's ASCII query-sequence byte stream into
// 2-bit-per-base chunks of PE_SIZE bases and serves them one at a time on a
// request / one-cycle-valid handshake. A pack buffer collects bases while a
// ready buffer holds the previous closed chunk, so the host can keep streaming
// while a chunk waits for its request.
// Optional build macro: SEQ_SKIP_INVALID_EN -- non-ACGT bytes are consumed but
// not stored (default build stores them as base A).
module seq_s_feeder #(
  parameter int PE_SIZE     = 64,
  parameter int PE_SIZE_LOG = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               i_char,
  input  logic                     i_char_valid,
  input  logic                     i_char_last,
  output logic                     o_char_ready,
  input  logic                     i_request_s,
  output logic [PE_SIZE*2-1:0]     o_s,
  output logic [PE_SIZE_LOG:0]     o_s_valid,
  output logic                     o_s_last,
  output logic                     o_bad_char
);

  localparam int CW = PE_SIZE_LOG + 1;
  localparam int DW = PE_SIZE * 2;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    STALL = 1'b1
  } state_t;

  // ASCII base to {bad, code}; anything outside ACGT/acgt is flagged bad.
  function automatic logic [2:0] encode(input logic [7:0] ch);
    logic [2:0] r;
    case (ch)
      8'h41, 8'h61: r = 3'b000;
      8'h43, 8'h63: r = 3'b001;
      8'h47, 8'h67: r = 3'b010;
      8'h54, 8'h74: r = 3'b011;
      default:      r = 3'b100;
    endcase
    return r;
  endfunction

  state_t          state;
  state_t          state_nxt;

  logic [DW-1:0]   pack_data;
  logic [CW-1:0]   pack_cnt;
  logic            pack_last;
  logic [DW-1:0]   rdy_data;
  logic [CW-1:0]   rdy_cnt;
  logic            rdy_last;
  logic            rdy_full;
  logic            pending;
  logic            seq_start;
  logic            char_ready;
  logic [DW-1:0]   s_data;
  logic [CW-1:0]   s_cnt;
  logic            s_last;
  logic            bad_char;

  logic [2:0]      enc;
  logic            char_bad;
  logic [1:0]      char_code;
  logic            accept;
  logic            write_en;
  logic [DW-1:0]   fill_data;
  logic [CW-1:0]   fill_cnt;
  logic            close;
  logic            deliver;
  logic            rdy_free;
  logic            transfer;
  logic            cand_last;
  logic            ready_nxt;

  assign enc       = encode(i_char);
  assign char_bad  = enc[2];
  assign char_code = enc[1:0];

  assign o_char_ready = char_ready;
  assign o_s          = s_data;
  assign o_s_valid    = s_cnt;
  assign o_s_last     = s_last;
  assign o_bad_char   = bad_char;

  // Datapath: byte acceptance, pack-buffer write, close and delivery decisions.
  always_comb begin
    accept = i_char_valid & char_ready;
`ifdef SEQ_SKIP_INVALID_EN
    write_en = accept & ~char_bad;
`else
    write_en = accept;
`endif
    fill_data = pack_data;
    if (write_en) begin
      fill_data[{pack_cnt[PE_SIZE_LOG-1:0], 1'b0} +: 2] = char_code;
    end else begin
      fill_data = pack_data;
    end
    fill_cnt = pack_cnt + {{(CW-1){1'b0}}, write_en};
    close    = accept & (i_char_last | (fill_cnt == CW'(PE_SIZE)));
    // A request seen this cycle is honoured immediately (1-cycle latency).
    deliver  = (pending | i_request_s) & rdy_full;
    // The ready buffer can take a chunk if empty or being emptied this edge.
    rdy_free = ~rdy_full | deliver;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: stall while a closed chunk cannot move to the ready buffer.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL: begin
        if (close & ~rdy_free) begin
          state_nxt = STALL;
        end else begin
          state_nxt = FILL;
        end
      end
      STALL: begin
        if (rdy_free) begin
          state_nxt = FILL;
        end else begin
          state_nxt = STALL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // FSM outputs: pack-to-ready transfer strobe and the registered ready value.
  always_comb begin
    transfer  = 1'b0;
    cand_last = 1'b0;
    case (state)
      FILL: begin
        transfer  = close & rdy_free;
        cand_last = i_char_last;
      end
      STALL: begin
        transfer  = rdy_free;
        cand_last = pack_last;
      end
      default: begin
        transfer  = 1'b0;
        cand_last = 1'b0;
      end
    endcase
    ready_nxt = (state_nxt == FILL);
  end

  // Pack buffer: collect bases, clear when the chunk moves to the ready buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_data <= '0;
      pack_cnt  <= '0;
      pack_last <= 1'b0;
    end else if (transfer) begin
      pack_data <= '0;
      pack_cnt  <= '0;
      pack_last <= 1'b0;
    end else if (accept) begin
      pack_data <= fill_data;
      pack_cnt  <= fill_cnt;
      pack_last <= i_char_last;
    end
  end

  // Ready buffer: load on transfer (in STALL fill_* equals the held pack), free on delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_data <= '0;
      rdy_cnt  <= '0;
      rdy_last <= 1'b0;
      rdy_full <= 1'b0;
    end else if (transfer) begin
      rdy_data <= fill_data;
      rdy_cnt  <= fill_cnt;
      rdy_last <= cand_last;
      rdy_full <= 1'b1;
    end else if (deliver) begin
      rdy_data <= '0;
      rdy_cnt  <= '0;
      rdy_last <= 1'b0;
      rdy_full <= 1'b0;
    end
  end

  // Chunk output: present the ready buffer for exactly one cycle per delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_data <= '0;
      s_cnt  <= '0;
      s_last <= 1'b0;
    end else if (deliver) begin
      s_data <= rdy_data;
      s_cnt  <= rdy_cnt;
      s_last <= rdy_last;
    end else begin
      s_data <= '0;
      s_cnt  <= '0;
      s_last <= 1'b0;
    end
  end

  // Control flags: one outstanding request, registered byte-ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= 1'b0;
      char_ready <= 1'b0;
    end else begin
      pending    <= (pending | i_request_s) & ~deliver;
      char_ready <= ready_nxt;
    end
  end

  // Sticky bad-character flag, restarted by the first byte of each sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_char  <= 1'b0;
      seq_start <= 1'b1;
    end else if (accept) begin
      bad_char  <= seq_start ? char_bad : (bad_char | char_bad);
      seq_start <= i_char_last;
    end
  end

endmodule

// File: tb/tb_seq_s_feeder.sv
// Bench for seq_s_feeder at PE_SIZE=4: directed vectors with literal
// expectations plus a chunk-queue model checked every cycle.
module tb_seq_s_feeder;

  localparam int P  = 4;
  localparam int PL = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [7:0]     i_char = 8'h00;
  logic           i_char_valid = 1'b0;
  logic           i_char_last = 1'b0;
  logic           o_char_ready;
  logic           i_request_s = 1'b0;
  logic [2*P-1:0] o_s;
  logic [PL:0]    o_s_valid;
  logic           o_s_last;
  logic           o_bad_char;

  int total = 0;
  int bad_cnt = 0;
  int deliveries = 0;
  int n_acc = 0;
  string stream_str;

  typedef struct {
    logic [2*P-1:0] data;
    int             cnt;
    logic           last;
  } chunk_t;

  chunk_t         exp_q[$];
  logic [2*P-1:0] m_data = '0;
  int             m_cnt = 0;
  logic           m_bad = 1'b0;
  logic           m_start = 1'b1;
  logic           m_req = 1'b0;

  seq_s_feeder #(.PE_SIZE(P), .PE_SIZE_LOG(PL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_char       (i_char),
    .i_char_valid (i_char_valid),
    .i_char_last  (i_char_last),
    .o_char_ready (o_char_ready),
    .i_request_s  (i_request_s),
    .o_s          (o_s),
    .o_s_valid    (o_s_valid),
    .o_s_last     (o_s_last),
    .o_bad_char   (o_bad_char)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad_cnt++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [2:0] base_code(input logic [7:0] ch);
    case (ch)
      "A", "a": return 3'b000;
      "C", "c": return 3'b001;
      "G", "g": return 3'b010;
      "T", "t": return 3'b011;
      default:  return 3'b100;
    endcase
  endfunction

  // Model and compare process: on each falling edge check outputs, then fold in
  // the byte / request that the next rising edge will consume.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_ready", o_char_ready, 0);
      check("rst_s", {o_s, o_s_valid, o_s_last}, 0);
      check("rst_bad", o_bad_char, 0);
      exp_q.delete();
      m_data = '0; m_cnt = 0; m_bad = 1'b0; m_start = 1'b1; m_req = 1'b0;
    end else begin
      check("model_bad", o_bad_char, m_bad);
      if (o_s_valid != 0 || o_s_last) begin
        deliveries++;
        check("model_requested", m_req, 1);
        m_req = 1'b0;
        if (exp_q.size() == 0) begin
          check("model_spurious_chunk", 1, 0);
        end else begin
          chunk_t c;
          c = exp_q.pop_front();
          check("model_s", o_s, c.data);
          check("model_cnt", o_s_valid, c.cnt);
          check("model_last", o_s_last, c.last);
        end
      end else begin
        check("model_idle_s", o_s, 0);
      end
      if (i_request_s) m_req = 1'b1;
      if (i_char_valid && o_char_ready) begin
        logic [2:0] e;
        chunk_t nc;
        e = base_code(i_char);
        m_bad = m_start ? e[2] : (m_bad | e[2]);
        m_start = i_char_last;
`ifdef SEQ_SKIP_INVALID_EN
        if (!e[2]) begin
          m_data[2*m_cnt +: 2] = e[1:0];
          m_cnt++;
        end
`else
        m_data[2*m_cnt +: 2] = e[1:0];
        m_cnt++;
`endif
        if (i_char_last || m_cnt == P) begin
          nc.data = m_data; nc.cnt = m_cnt; nc.last = i_char_last;
          exp_q.push_back(nc);
          m_data = '0; m_cnt = 0;
        end
      end
    end
  end

  // Drive one byte until accepted; starts and ends 1ns after a rising edge.
  task automatic send(input logic [7:0] ch, input logic last);
    int n = 0;
    logic acc = 1'b0;
    i_char = ch; i_char_last = last; i_char_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = o_char_ready;
      n++;
      @(posedge clk); #1;
    end
    i_char_valid = 1'b0; i_char_last = 1'b0;
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic send_str(input string s, input logic last_on_end);
    for (int i = 0; i < s.len(); i++)
      send(s[i], last_on_end && (i == s.len() - 1));
  endtask

  task automatic request();
    i_request_s = 1'b1;
    @(posedge clk); #1;
    i_request_s = 1'b0;
  endtask

  // Stream stream_str with valid held high until target bytes or max cycles.
  task automatic stream(input int target, input int max_cyc);
    for (int c = 0; c < max_cyc && n_acc < target; c++) begin
      i_char = stream_str[n_acc];
      i_char_last = (n_acc == stream_str.len() - 1);
      i_char_valid = 1'b1;
      @(negedge clk);
      if (o_char_ready) n_acc++;
      @(posedge clk); #1;
    end
    i_char_valid = 1'b0; i_char_last = 1'b0;
  endtask

  // Wait (bounded) for a presented chunk and compare with literal values.
  task automatic wait_delivery(input logic [7:0] es, input int ec, input logic el,
                               input int ewait, input string nm);
    int n = 0;
    logic got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (o_s_valid != 0 || o_s_last) got = 1'b1;
    end
    check({nm, "_arrived"}, got, 1);
    if (got) begin
      check({nm, "_s"}, o_s, es);
      check({nm, "_cnt"}, o_s_valid, ec);
      check({nm, "_last"}, o_s_last, el);
      if (ewait > 0) check({nm, "_latency"}, n, ewait);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_deliv;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", o_char_ready, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_release", o_char_ready, 1);

    // 1: exact multiple of PE_SIZE, last on the 4th base.
    send_str("ACGT", 1'b1);
    request();
    wait_delivery(8'b11100100, 4, 1'b1, 1, "t1");
    @(negedge clk);
    check("t1_zero_after", {o_s, o_s_valid, o_s_last}, 0);
    @(posedge clk); #1;

    // 2: two chunks, second partial.
    send_str("ACGTAC", 1'b1);
    request();
    wait_delivery(8'b11100100, 4, 1'b0, 1, "t2a");
    repeat (2) @(posedge clk);
    #1;
    request();
    wait_delivery(8'b00000100, 2, 1'b1, 1, "t2b");

    // 3: request before data.
    request();
    send_str("gggg", 1'b1);
    wait_delivery(8'hAA, 4, 1'b1, 2, "t3");
    repeat (4) @(posedge clk);
    #1;

    // 4: back-pressure after both buffers fill.
    stream_str = "ACGTACGTACGT";
    n_acc = 0;
    stream(12, 12);
    check("t4_accepted_before_stall", n_acc, 8);
    @(negedge clk);
    check("t4_ready_low", o_char_ready, 0);
    @(posedge clk); #1;
    request();
    @(negedge clk);
    check("t4_ready_back", o_char_ready, 1);
    @(posedge clk); #1;
    stream(12, 20);
    check("t4_accepted_all", n_acc, 12);
    request();
    wait_delivery(8'b11100100, 4, 1'b0, 1, "t4b");
    request();
    wait_delivery(8'b11100100, 4, 1'b1, 1, "t4c");

    // 5: invalid character handling, then bad flag restart.
    send_str("ANGT", 1'b1);
    @(negedge clk);
    check("t5_bad_set", o_bad_char, 1);
    @(posedge clk); #1;
    request();
`ifdef SEQ_SKIP_INVALID_EN
    wait_delivery(8'b00111000, 3, 1'b1, 1, "t5");
`else
    wait_delivery(8'b11100000, 4, 1'b1, 1, "t5");
`endif
    send("T", 1'b1);
    @(negedge clk);
    check("t5_bad_cleared", o_bad_char, 0);
    @(posedge clk); #1;
    request();
    wait_delivery(8'b00000011, 1, 1'b1, 1, "t5_single");
`ifdef SEQ_SKIP_INVALID_EN
    send("N", 1'b1);
    request();
    wait_delivery(8'b00000000, 0, 1'b1, 1, "t5_empty_last");
`endif

    // 6: reset mid-fill with a request pending.
    send("A", 1'b0);
    send("N", 1'b0);
    request();
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_outputs", {o_char_ready, o_s, o_s_valid, o_s_last, o_bad_char}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_ready_after_release", o_char_ready, 1);
    @(posedge clk); #1;
    send("T", 1'b1);
    repeat (2) begin
      @(negedge clk);
      check("t6_no_stale_request", o_s_valid, 0);
    end
    @(posedge clk); #1;
    request();
    wait_delivery(8'b00000011, 1, 1'b1, 1, "t6");

    repeat (3) @(posedge clk);
`ifdef SEQ_SKIP_INVALID_EN
    exp_deliv = 11;
`else
    exp_deliv = 10;
`endif
    check("total_deliveries", deliveries, exp_deliv);
    check("model_queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad_cnt);
    $finish;
  end

endmodule

// File: doc/seq_s_feeder.md
Name: seq_s_feeder

Overview:
- Upstream of the accelerator top: converts the host's ASCII query-sequence (S) byte stream into 2-bit packed chunks.
- Serves them on the top's o_request_s / i_s / i_s_valid handshake.
- Double-buffered: host can keep filling the next chunk while the current chunk waits for a request.

Parameters:
- PE_SIZE, 64, bases per chunk; equals PE array size.
- PE_SIZE_LOG, 6, log2(PE_SIZE); count field is PE_SIZE_LOG+1 bits.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active low.
- i_char  in  8  ASCII base from host.
- i_char_valid  in  1  i_char valid.
- i_char_last  in  1  qualifies the final byte of a sequence.
- o_char_ready  out  1  byte accepted when i_char_valid & o_char_ready.
- i_request_s  in  1  chunk request pulse (driven from top o_request_s).
- o_s  out  PE_SIZE*2  packed chunk; base k at [2k+1:2k], base 0 = earliest received.
- o_s_valid  out  PE_SIZE_LOG+1  number of valid bases in o_s; 0 = nothing presented.
- o_s_last  out  1  presented chunk is the final chunk of the sequence.
- o_bad_char  out  1  sticky: a non-ACGT byte was received; cleared by the next accepted byte that starts a sequence.

Behaviour:
- Reset: o_char_ready=0, o_s=0, o_s_valid=0, o_s_last=0, o_bad_char=0; both buffers empty; pending request cleared; state FILL.
- o_char_ready is 1 in the cycle after reset release, subject to the rules below.
- Encoding:
  - A/a=0, C/c=1, G/g=2, T/t=3.
  - Any other byte encodes as 0 and sets o_bad_char.
- Pack buffer: fill counter 0..PE_SIZE. An accepted byte writes its code at slot = counter, then the counter increments.
- Pack buffer closes on either condition:
  - counter reaches PE_SIZE;
  - i_char_last is accepted; count is bases so far and last flag is set.
- On close, the pack buffer moves to the ready buffer in the same edge if the ready buffer is empty. Otherwise it stays closed, and o_char_ready=0 until the transfer happens.
- Unused slots of a partial chunk are zero.
- States:
  - FILL: accepting bytes.
  - STALL: pack buffer closed while ready buffer occupied.
  - FILL/STALL both feed ready-buffer handling independently.
- Requests:
  - i_request_s sets a pending flag.
  - When pending & ready buffer occupied: o_s, o_s_valid, o_s_last are driven for exactly one cycle (the next edge), then return to 0. Pending and ready buffer clear on that same edge.
  - Minimum latency is 1 cycle from request to data.
- Request with empty ready buffer: stays pending, no output, until a chunk arrives.
  - A request arriving while already pending is absorbed; at most one outstanding.
- Simultaneous events:
  - Close and transfer in the cycle the ready buffer is being delivered: allowed. The new chunk enters the ready buffer on the same edge the old one is presented.
- Sequence length an exact multiple of PE_SIZE: the final full chunk carries o_s_last=1 and count=PE_SIZE. No extra empty chunk is produced.
- i_char_last with zero prior bases in the pack buffer (1-byte sequence): chunk count=1, last=1.
- After a last chunk is delivered, filling continues for the next sequence with no idle cycle. o_bad_char is cleared when the first byte of the new sequence is accepted.
- Reset mid-operation: all buffers, counters and pending flag cleared immediately; partially packed data is discarded.

Optional Feature:
- SEQ_SKIP_INVALID_EN.
- Defined:
  - Non-ACGT bytes are consumed (o_char_ready handshake completes) but not written, and the counter does not advance.
  - o_bad_char still sets.
  - A skipped byte carrying i_char_last still closes the chunk with the bases collected so far. This may give count=0 with last=1, which is presented as o_s_valid=0, o_s_last=1 for one cycle.
- Undefined: invalid bytes encode as A (0) and occupy a slot.

Test Plan:
- PE_SIZE=4; send "ACGT" with last on T, then request → one cycle later o_s=8'b11100100, o_s_valid=4, o_s_last=1; next cycle all zero.
- PE_SIZE=4; send "ACGTAC" last on C, two requests spaced 3 cycles → first chunk count=4/last=0; second o_s=8'b00000100, count=2, last=1.
- Request before any data, then stream "gggg" last → output occurs 1 cycle after the 4th byte transfers into the ready buffer: o_s=8'hAA, count=4, last=1; only one delivery.
- PE_SIZE=4; stream 12 bases without requesting → o_char_ready drops after 8 accepted bytes (both buffers full); one request frees space and ready returns.
- Send "ANGT" → default: o_s=8'b11100000, count=4, o_bad_char=1. With SEQ_SKIP_INVALID_EN: count=3, o_s=8'b00111000, o_bad_char=1.
- Assert rst_n low mid-fill after 2 bytes with request pending → all outputs 0; after release a fresh "T" with last plus request yields count=1, o_s=8'b00000011.
